// File: rtl/oven_pkg.sv
// Constants shared by the oven timer and its displays: active-high
// 7-segment patterns {g,f,e,d,c,b,a} and digit slot indices.
package oven_pkg;

   localparam logic [6:0] SEG_0    = 7'h3F;
   localparam logic [6:0] SEG_1    = 7'h06;
   localparam logic [6:0] SEG_2    = 7'h5B;
   localparam logic [6:0] SEG_3    = 7'h4F;
   localparam logic [6:0] SEG_4    = 7'h66;
   localparam logic [6:0] SEG_5    = 7'h6D;
   localparam logic [6:0] SEG_6    = 7'h7D;
   localparam logic [6:0] SEG_7    = 7'h07;
   localparam logic [6:0] SEG_8    = 7'h7F;
   localparam logic [6:0] SEG_9    = 7'h6F;
   localparam logic [6:0] SEG_DASH = 7'h40;

   localparam logic DIG_UNITS = 1'b0;
   localparam logic DIG_TENS  = 1'b1;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD nibble to active-high 7-segment pattern; any
// nibble above 9 renders as a dash.
module bcd_to_seg
   import oven_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/timer_display.sv
// Two-digit multiplexed 7-segment driver for the oven timer: per-frame
// snapshot, leading-zero blanking, dash for bad nibbles, blink on timeout.
module timer_display
   import oven_pkg::*;
#(
   parameter int REFRESH_DIV = 50000,
   parameter int BLINK_DIV   = 250,
   parameter bit ACTIVE_LOW  = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] digit_time,
   input  logic       timeout,
   output logic [6:0] seg,
   output logic [1:0] an
);

   localparam int PRE_W = $clog2(REFRESH_DIV);
   localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
   localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);
   localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic [1:0] AN_OFF  = ACTIVE_LOW ? 2'b11 : 2'b00;

   logic [PRE_W-1:0] pre_cnt;
   logic             sel;
   logic [7:0]       snap;
   logic [BLK_W-1:0] blink_cnt;
   logic             blink_on;
   logic             first_cyc;
   logic             slot_end;
   logic             frame_start;
   logic [3:0]       nibble;
   logic [6:0]       seg_hi;
   logic [1:0]       an_hi;

   // The cycle right after reset only captures the snapshot, so the
   // first units slot at the pins is a full REFRESH_DIV cycles long.
   assign slot_end    = !first_cyc && (pre_cnt == PRE_LAST);
   assign frame_start = first_cyc || (slot_end && (sel == DIG_TENS));

   always_comb begin
      nibble = (sel == DIG_TENS) ? snap[7:4] : snap[3:0];
   end

   bcd_to_seg u_dec (
      .bcd (nibble),
      .seg (seg_hi)
   );

   always_comb begin
      an_hi = 2'b00;
      if (blink_on) begin
         if (sel == DIG_UNITS)
            an_hi = 2'b01;
         else if (snap[7:4] != 4'd0)
            an_hi = 2'b10;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pre_cnt   <= '0;
         sel       <= DIG_UNITS;
         snap      <= 8'h00;
         blink_cnt <= '0;
         blink_on  <= 1'b1;
         first_cyc <= 1'b1;
         seg       <= SEG_OFF;
         an        <= AN_OFF;
      end else begin
         first_cyc <= 1'b0;

         if (slot_end)
            pre_cnt <= '0;
         else if (!first_cyc)
            pre_cnt <= pre_cnt + 1'b1;

         if (slot_end)
            sel <= ~sel;

         if (frame_start)
            snap <= digit_time;

         // Dropping timeout clears the blink state even on a slot_end cycle.
         if (!timeout) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
         end else if (slot_end) begin
            if (blink_cnt == BLK_LAST) begin
               blink_cnt <= '0;
               blink_on  <= ~blink_on;
            end else begin
               blink_cnt <= blink_cnt + 1'b1;
            end
         end

         if (first_cyc) begin
            seg <= SEG_OFF;
            an  <= AN_OFF;
         end else begin
            seg <= ACTIVE_LOW ? ~seg_hi : seg_hi;
            an  <= ACTIVE_LOW ? ~an_hi : an_hi;
         end
      end
   end

endmodule

// File: tb/tb_timer_display.sv
// Self-checking bench for timer_display with a timeline-based reference
// model plus hand-computed pin values for the directed scenarios.
module tb_timer_display;

   localparam int R = 4;
   localparam int B = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] digit_time = 8'h99;
   logic       timeout = 1'b0;
   logic [6:0] seg;
   logic [1:0] an;

   int n_checks = 0;
   int n_fail = 0;

   logic [6:0] exp_seg = 7'h7F;
   logic [1:0] exp_an = 2'b11;

   int         m_t = 0;
   bit         m_first = 1'b1;
   logic [7:0] m_snap = 8'h00;
   bit         m_on = 1'b1;
   int         m_cnt = 0;

   timer_display #(
      .REFRESH_DIV (R),
      .BLINK_DIV   (B),
      .ACTIVE_LOW  (1'b1)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .digit_time (digit_time),
      .timeout    (timeout),
      .seg        (seg),
      .an         (an)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] segOf(input logic [3:0] n);
      case (n)
         4'd0: return 7'h3F;
         4'd1: return 7'h06;
         4'd2: return 7'h5B;
         4'd3: return 7'h4F;
         4'd4: return 7'h66;
         4'd5: return 7'h6D;
         4'd6: return 7'h7D;
         4'd7: return 7'h07;
         4'd8: return 7'h7F;
         4'd9: return 7'h6F;
         default: return 7'h40;
      endcase
   endfunction

   // Reference model: m_t counts edges since the post-reset capture edge;
   // pins at edge t show slot (t-1)/R, frames reload every 2R edges.
   always @(posedge clk) begin
      int  k;
      bit  units;
      if (!rst_n) begin
         exp_seg = 7'h7F;
         exp_an  = 2'b11;
         m_first = 1'b1;
         m_t     = 0;
         m_on    = 1'b1;
         m_cnt   = 0;
      end else if (m_first) begin
         m_first = 1'b0;
         m_t     = 0;
         m_snap  = digit_time;
         exp_seg = 7'h7F;
         exp_an  = 2'b11;
      end else begin
         m_t   = m_t + 1;
         k     = (m_t - 1) / R;
         units = (k % 2) == 0;
         exp_seg = ~segOf(units ? m_snap[3:0] : m_snap[7:4]);
         if (!m_on)
            exp_an = 2'b11;
         else if (units)
            exp_an = 2'b10;
         else if (m_snap[7:4] == 4'd0)
            exp_an = 2'b11;
         else
            exp_an = 2'b01;
         if (m_t % (2 * R) == 0)
            m_snap = digit_time;
         if (!timeout) begin
            m_on  = 1'b1;
            m_cnt = 0;
         end else if (m_t % R == 0) begin
            m_cnt = m_cnt + 1;
            if (m_cnt == B) begin
               m_cnt = 0;
               m_on  = !m_on;
            end
         end
      end
   end

   task automatic applyStimulus(input logic [7:0] dt, input logic to, input logic rn);
      digit_time = dt;
      timeout    = to;
      rst_n      = rn;
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
      n_checks++;
      if (seg !== exp_seg || an !== exp_an) begin
         n_fail++;
         $display("[TB] FAIL model t=%0d: seg=%h an=%b, required seg=%h an=%b",
                  m_t, seg, an, exp_seg, exp_an);
      end
   endtask

   task automatic checkOutput(input string name, input logic [6:0] s, input logic [1:0] a);
      n_checks++;
      if (seg !== s || an !== a) begin
         n_fail++;
         $display("[TB] FAIL %s: seg=%h an=%b, required seg=%h an=%b", name, seg, an, s, a);
      end
   endtask

   task automatic checkRun(input int n, input string name, input logic [6:0] s, input logic [1:0] a);
      repeat (n) begin
         stepCycle();
         checkOutput(name, s, a);
      end
   endtask

   initial begin
      applyStimulus(8'h99, 1'b0, 1'b0);
      checkRun(3, "reset", 7'h7F, 2'b11);

      applyStimulus(8'h42, 1'b0, 1'b1);
      checkRun(1, "first_cycle", 7'h7F, 2'b11);
      checkRun(4, "scan_units", 7'h24, 2'b10);
      checkRun(4, "scan_tens", 7'h19, 2'b01);

      checkRun(1, "snap_units_old", 7'h24, 2'b10);
      applyStimulus(8'h15, 1'b0, 1'b1);
      checkRun(3, "snap_units_held", 7'h24, 2'b10);
      checkRun(4, "snap_tens_held", 7'h19, 2'b01);
      checkRun(4, "snap_units_new", 7'h12, 2'b10);
      checkRun(1, "snap_tens_new", 7'h79, 2'b01);

      applyStimulus(8'h07, 1'b0, 1'b1);
      checkRun(3, "snap_tens_new", 7'h79, 2'b01);
      checkRun(4, "lz_units", 7'h78, 2'b10);
      checkRun(1, "lz_tens_blank", 7'h40, 2'b11);

      applyStimulus(8'hA3, 1'b0, 1'b1);
      checkRun(3, "lz_tens_blank", 7'h40, 2'b11);
      checkRun(4, "inv_units", 7'h30, 2'b10);
      checkRun(1, "inv_tens_dash", 7'h3F, 2'b01);

      applyStimulus(8'h42, 1'b0, 1'b1);
      checkRun(3, "inv_tens_dash", 7'h3F, 2'b01);

      applyStimulus(8'h42, 1'b1, 1'b1);
      checkRun(4, "blink_on_units", 7'h24, 2'b10);
      checkRun(4, "blink_on_tens", 7'h19, 2'b01);
      checkRun(4, "blink_off_units", 7'h24, 2'b11);
      checkRun(4, "blink_off_tens", 7'h19, 2'b11);
      checkRun(4, "blink_back_units", 7'h24, 2'b10);
      checkRun(4, "blink_back_tens", 7'h19, 2'b01);
      checkRun(2, "blink_off_again", 7'h24, 2'b11);

      applyStimulus(8'h42, 1'b0, 1'b1);
      checkRun(1, "timeout_fall_wait", 7'h24, 2'b11);
      checkRun(1, "timeout_fall_restore", 7'h24, 2'b10);
      checkRun(2, "restored_tens", 7'h19, 2'b01);

      applyStimulus(8'h42, 1'b0, 1'b0);
      checkRun(2, "reset_mid_frame", 7'h7F, 2'b11);

      applyStimulus(8'h58, 1'b0, 1'b1);
      checkRun(1, "rerelease_first", 7'h7F, 2'b11);
      checkRun(4, "post_reset_units", 7'h00, 2'b10);
      checkRun(4, "post_reset_tens", 7'h12, 2'b01);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
